bird_launcher: RTL and testbench
================================

BIRD_LAUNCHER -- requirements
Module: bird_launcher

Interface
REQ-001 The block SHALL have parameter GAP_FRAMES, default 30; the frame ticks between birds (range 1..65535).
REQ-002 The block SHALL have parameter FLIGHT_FRAMES, default 300; the frame ticks a bird flies before escaping (range 1..65535).
REQ-003 The block SHALL have parameter FALL_FRAMES, default 60; the frame ticks a shot bird falls (range 1..65535).
REQ-004 The block SHALL have port Clk, input, 1, the single system clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port Reset, input, 1, a synchronous active-high reset.
REQ-006 The block SHALL have port frame_tick, input, 1, a one-Clk-cycle pulse once per video frame.
REQ-007 The block SHALL have port state, input, 2, the game state: 2'b00 title, 2'b01 play, 2'b10 game over, 2'b11 reserved and treated as title.
REQ-008 The block SHALL have port hit, input, 1, a level that is high while the player's shot registers on the active bird.
REQ-009 The block SHALL have port no_birds_left, input, 1, a level from the bird-escape counter.
REQ-010 The block SHALL have port flew_away, output, 1, the escape indication that drives the bird-escape counter.
REQ-011 The block SHALL have port bird_active, output, 1, high while a bird is flying and shootable.
REQ-012 The block SHALL have port bird_falling, output, 1, high while a shot bird falls.
REQ-013 The block SHALL have port phase_timer, output, 16, the frame ticks elapsed in the current timed phase.
REQ-014 The block SHALL have port birds_launched, output, 32, the count of birds launched.
REQ-015 The block SHALL have port birds_shot, output, 32, the count of birds hit.

Function
REQ-016 The FSM SHALL have the states IDLE, GAP, FLYING, FALLING, ESCAPED and DONE.
REQ-017 IDLE SHALL go to GAP, with phase_timer cleared, on the first Clk cycle with state==2'b01 and no_birds_left==0.
REQ-018 GAP SHALL increment phase_timer on each frame_tick.
REQ-019 GAP SHALL go to DONE if no_birds_left==1, checked before the timer.
REQ-020 GAP SHALL otherwise go to FLYING on the frame_tick that makes phase_timer==GAP_FRAMES; this transition SHALL clear phase_timer and increment birds_launched.
REQ-021 In FLYING, bird_active SHALL be 1 and phase_timer SHALL increment on each frame_tick.
REQ-022 FLYING SHALL go to FALLING on any Clk cycle with hit==1; this transition SHALL increment birds_shot and clear phase_timer.
REQ-023 FLYING SHALL otherwise go to ESCAPED on the frame_tick that makes phase_timer==FLIGHT_FRAMES.
REQ-024 If hit and the escaping frame_tick occur in the same cycle, hit SHALL win.
REQ-025 hit outside FLYING SHALL be ignored.
REQ-026 FALLING SHALL hold bird_falling=1 and SHALL go to GAP, with phase_timer cleared, on the frame_tick that makes phase_timer==FALL_FRAMES.
REQ-027 ESCAPED SHALL hold flew_away=1 from entry until the next frame_tick, then go to GAP with phase_timer cleared.
REQ-028 flew_away SHALL therefore be high for at least 1 Clk cycle and be low before the next escape.
REQ-029 Each escape SHALL produce exactly one rising edge on flew_away.
REQ-030 DONE SHALL drive all status outputs to 0 and hold the counters.
REQ-031 DONE SHALL go to IDLE when state!=2'b01.
REQ-032 From any state, state!=2'b01 SHALL force IDLE on the next Clk cycle, clear phase_timer and deassert bird_active, bird_falling and flew_away.
REQ-033 The counters SHALL keep their values across that forced IDLE.
REQ-034 The counters SHALL clear on the IDLE->GAP transition when the previous state value was 2'b10 (new game after game over).
REQ-035 Counters SHALL be unsigned and wrap modulo 2^32.
REQ-036 phase_timer SHALL saturate at 16'hFFFF.
REQ-037 bird_active, bird_falling and flew_away SHALL be registered outputs, mutually exclusive, and decoded only from the current FSM state.
REQ-038 frame_tick outside GAP, FLYING, FALLING and ESCAPED SHALL have no effect.

Reset
REQ-039 With Reset==1 at a Clk edge, the FSM SHALL be IDLE and flew_away, bird_active and bird_falling SHALL be 0.
REQ-040 With Reset==1 at a Clk edge, phase_timer SHALL be 16'd0 and birds_launched and birds_shot SHALL be 32'd0.
REQ-041 The previous-state register SHALL reset to 2'b00.
REQ-042 Reset SHALL take priority over every other input, including mid-flight and mid-escape.
REQ-043 Reset asserted in ESCAPED SHALL drop flew_away the next cycle with no further pulse.

Verification
REQ-044 The bench SHALL use GAP_FRAMES=2, FLIGHT_FRAMES=4 and FALL_FRAMES=3, with frame_tick every 4 Clk cycles.
REQ-045 Escape: state=01, no hit -> bird_active high for 4 ticks, flew_away high until the next tick, birds_launched=1, birds_shot=0.
REQ-046 Hit: hit pulsed 2 ticks into the flight -> FALLING next cycle, bird_falling high for 3 ticks, birds_shot=1, flew_away never high.
REQ-047 Simultaneous: hit asserted in the same cycle as the 4th flight tick -> FALLING, not ESCAPED; birds_shot increments.
REQ-048 Game end: no_birds_left driven high during GAP -> DONE, with no further launch over 20 ticks; state=10 then 01 -> counters clear and launching resumes.
REQ-049 Abort: state=00 mid-FLYING -> IDLE next cycle, bird_active=0, counters held.
REQ-050 Reset: Reset pulsed while flew_away=1 -> all outputs 0 next cycle and the FSM in IDLE.

Source files
------------

// File: rtl/bird_launcher_if.sv
// Game-side signals of the bird launcher: frame/game-state inputs and
// bird status and counter outputs.
interface bird_launcher_if;
    logic        frame_tick;
    logic [1:0]  state;
    logic        hit;
    logic        no_birds_left;
    logic        flew_away;
    logic        bird_active;
    logic        bird_falling;
    logic [15:0] phase_timer;
    logic [31:0] birds_launched;
    logic [31:0] birds_shot;

    modport master (
        output frame_tick, state, hit, no_birds_left,
        input  flew_away, bird_active, bird_falling, phase_timer,
               birds_launched, birds_shot
    );

    modport slave (
        input  frame_tick, state, hit, no_birds_left,
        output flew_away, bird_active, bird_falling, phase_timer,
               birds_launched, birds_shot
    );
endinterface

// File: rtl/bird_launcher.sv
// Bird launch sequencer: gap -> flight -> (fall | escape) -> gap, timed in
// video frames, with launch/hit counters that survive aborts.
module bird_launcher #(
    parameter int unsigned GAP_FRAMES    = 30,
    parameter int unsigned FLIGHT_FRAMES = 300,
    parameter int unsigned FALL_FRAMES   = 60
) (
    input  logic             Clk,
    input  logic             Reset,
    bird_launcher_if.slave   bus
);
    localparam logic [15:0] GAP_LIMIT    = 16'(GAP_FRAMES);
    localparam logic [15:0] FLIGHT_LIMIT = 16'(FLIGHT_FRAMES);
    localparam logic [15:0] FALL_LIMIT   = 16'(FALL_FRAMES);

    typedef enum logic [2:0] {
        IDLE, GAP, FLYING, FALLING, ESCAPED, DONE
    } fsm_t;

    fsm_t        fsm_reg, fsm_next;
    logic [15:0] timer_reg, timer_next, timer_inc;
    logic [31:0] launched_reg, launched_next;
    logic [31:0] shot_reg, shot_next;
    logic [1:0]  prev_state_reg;
    logic        active_reg, falling_reg, flew_reg;

    assign timer_inc = (timer_reg == 16'hFFFF) ? timer_reg : timer_reg + 16'd1;

    always_comb begin
        fsm_next      = fsm_reg;
        timer_next    = timer_reg;
        launched_next = launched_reg;
        shot_next     = shot_reg;
        // Leaving play aborts whatever is in progress; counters are kept.
        if (bus.state != 2'b01) begin
            fsm_next   = IDLE;
            timer_next = '0;
        end else begin
            case (fsm_reg)
                IDLE: begin
                    if (!bus.no_birds_left) begin
                        fsm_next   = GAP;
                        timer_next = '0;
                        if (prev_state_reg == 2'b10) begin
                            launched_next = '0;
                            shot_next     = '0;
                        end
                    end
                end
                GAP: begin
                    if (bus.no_birds_left) begin
                        fsm_next   = DONE;
                        timer_next = '0;
                    end else if (bus.frame_tick) begin
                        if (timer_inc == GAP_LIMIT) begin
                            fsm_next      = FLYING;
                            timer_next    = '0;
                            launched_next = launched_reg + 32'd1;
                        end else begin
                            timer_next = timer_inc;
                        end
                    end
                end
                FLYING: begin
                    // A hit beats an escape landing on the same cycle.
                    if (bus.hit) begin
                        fsm_next   = FALLING;
                        timer_next = '0;
                        shot_next  = shot_reg + 32'd1;
                    end else if (bus.frame_tick) begin
                        timer_next = timer_inc;
                        if (timer_inc == FLIGHT_LIMIT) begin
                            fsm_next = ESCAPED;
                        end
                    end
                end
                FALLING: begin
                    if (bus.frame_tick) begin
                        if (timer_inc == FALL_LIMIT) begin
                            fsm_next   = GAP;
                            timer_next = '0;
                        end else begin
                            timer_next = timer_inc;
                        end
                    end
                end
                ESCAPED: begin
                    if (bus.frame_tick) begin
                        fsm_next   = GAP;
                        timer_next = '0;
                    end
                end
                DONE: begin
                end
                default: begin
                    fsm_next   = IDLE;
                    timer_next = '0;
                end
            endcase
        end
    end

    // Status flags are registered from the next state so they track fsm_reg exactly.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            fsm_reg        <= IDLE;
            timer_reg      <= '0;
            launched_reg   <= '0;
            shot_reg       <= '0;
            prev_state_reg <= 2'b00;
            active_reg     <= 1'b0;
            falling_reg    <= 1'b0;
            flew_reg       <= 1'b0;
        end else begin
            fsm_reg        <= fsm_next;
            timer_reg      <= timer_next;
            launched_reg   <= launched_next;
            shot_reg       <= shot_next;
            prev_state_reg <= bus.state;
            active_reg     <= (fsm_next == FLYING);
            falling_reg    <= (fsm_next == FALLING);
            flew_reg       <= (fsm_next == ESCAPED);
        end
    end

    assign bus.bird_active    = active_reg;
    assign bus.bird_falling   = falling_reg;
    assign bus.flew_away      = flew_reg;
    assign bus.phase_timer    = timer_reg;
    assign bus.birds_launched = launched_reg;
    assign bus.birds_shot     = shot_reg;
endmodule

// File: tb/tb_bird_launcher.sv
// Randomized + directed bench for bird_launcher: a frame-rule reference model
// queues expected output events, a monitor matches them as the DUT changes.
module tb_bird_launcher;
    localparam int GAP    = 2;
    localparam int FLIGHT = 4;
    localparam int FALL   = 3;

    typedef struct {
        logic        a;
        logic        f;
        logic        e;
        logic [15:0] t;
        logic [31:0] l;
        logic [31:0] s;
        int          cyc;
    } snap_t;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    bird_launcher_if bus ();

    bird_launcher #(
        .GAP_FRAMES   (GAP),
        .FLIGHT_FRAMES(FLIGHT),
        .FALL_FRAMES  (FALL)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    int    checks   = 0;
    int    failures = 0;
    int    cyc      = 0;
    snap_t exp_q[$];

    // Reference model: phase 0 idle, 1 gap, 2 flying, 3 falling, 4 escaped, 5 done
    int          m_ph   = 0;
    logic [15:0] m_t    = '0;
    logic [31:0] m_l    = '0;
    logic [31:0] m_s    = '0;
    logic [1:0]  m_prev = 2'b00;
    snap_t       m_last;

    function automatic logic [15:0] bump(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic void model_step(input logic rst, input logic tick,
                                       input logic [1:0] st, input logic h,
                                       input logic nbl);
        if (rst) begin
            m_ph = 0; m_t = '0; m_l = '0; m_s = '0; m_prev = 2'b00;
            return;
        end
        if (st != 2'b01) begin
            m_ph = 0; m_t = '0;
        end else if (m_ph == 0) begin
            if (!nbl) begin
                if (m_prev == 2'b10) begin m_l = '0; m_s = '0; end
                m_ph = 1; m_t = '0;
            end
        end else if (m_ph == 1) begin
            if (nbl) begin
                m_ph = 5; m_t = '0;
            end else if (tick) begin
                m_t = bump(m_t);
                if (m_t == 16'(GAP)) begin m_ph = 2; m_t = '0; m_l = m_l + 1; end
            end
        end else if (m_ph == 2) begin
            if (h) begin
                m_ph = 3; m_t = '0; m_s = m_s + 1;
            end else if (tick) begin
                m_t = bump(m_t);
                if (m_t == 16'(FLIGHT)) m_ph = 4;
            end
        end else if (m_ph == 3) begin
            if (tick) begin
                m_t = bump(m_t);
                if (m_t == 16'(FALL)) begin m_ph = 1; m_t = '0; end
            end
        end else if (m_ph == 4) begin
            if (tick) begin m_ph = 1; m_t = '0; end
        end
        m_prev = st;
    endfunction

    initial begin
        snap_t s;
        m_last = '{a: 1'b0, f: 1'b0, e: 1'b0, t: 16'd0, l: 32'd0, s: 32'd0, cyc: 0};
        forever begin
            @(posedge Clk);
            cyc++;
            model_step(Reset, bus.frame_tick, bus.state, bus.hit, bus.no_birds_left);
            s = '{a: (m_ph == 2), f: (m_ph == 3), e: (m_ph == 4), t: m_t, l: m_l, s: m_s, cyc: cyc};
            if (s.a != m_last.a || s.f != m_last.f || s.e != m_last.e ||
                s.l != m_last.l || s.s != m_last.s)
                exp_q.push_back(s);
            m_last = s;
        end
    end

    // Monitor: any change in flags or counters is one transaction.
    logic        d_a = 1'b0, d_f = 1'b0, d_e = 1'b0;
    logic [31:0] d_l = '0, d_s = '0;
    initial begin
        snap_t e;
        forever begin
            @(negedge Clk);
            if (bus.bird_active !== d_a || bus.bird_falling !== d_f ||
                bus.flew_away !== d_e || bus.birds_launched !== d_l ||
                bus.birds_shot !== d_s) begin
                d_a = bus.bird_active; d_f = bus.bird_falling; d_e = bus.flew_away;
                d_l = bus.birds_launched; d_s = bus.birds_shot;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_event cyc=%0d actual a=%b f=%b e=%b l=%0d s=%0d required no event",
                             cyc, d_a, d_f, d_e, d_l, d_s);
                end else begin
                    e = exp_q.pop_front();
                    $display("txn cyc=%0d active=%b falling=%b flew=%b timer=%0d launched=%0d shot=%0d",
                             cyc, d_a, d_f, d_e, bus.phase_timer, d_l, d_s);
                    if (e.cyc != cyc || e.a !== d_a || e.f !== d_f || e.e !== d_e ||
                        e.t !== bus.phase_timer || e.l !== d_l || e.s !== d_s) begin
                        failures++;
                        $display("FAIL event actual cyc=%0d a=%b f=%b e=%b t=%0d l=%0d s=%0d required cyc=%0d a=%b f=%b e=%b t=%0d l=%0d s=%0d",
                                 cyc, d_a, d_f, d_e, bus.phase_timer, d_l, d_s,
                                 e.cyc, e.a, e.f, e.e, e.t, e.l, e.s);
                    end
                end
            end
        end
    end

    // Frame tick: one cycle in every four.
    initial begin
        int tick_cnt = 0;
        bus.frame_tick = 1'b0;
        forever begin
            @(posedge Clk);
            #1;
            bus.frame_tick = (tick_cnt == 3);
            tick_cnt = (tick_cnt + 1) % 4;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step_cycle();
        @(posedge Clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return bus.bird_active;
            1:       return bus.bird_falling;
            default: return bus.flew_away;
        endcase
    endfunction

    task automatic wait_level(input string name, input int sel, input logic val, input int budget);
        int n = 0;
        while (sig(sel) !== val && n < budget) begin
            step_cycle();
            n++;
        end
        if (sig(sel) !== val) begin
            checks++;
            failures++;
            $display("FAIL timeout_%s actual=%b required=%b", name, sig(sel), val);
        end
    endtask

    task automatic wait_ticks(input int n);
        int cnt = 0;
        int guard = 0;
        while (cnt < n && guard < 100) begin
            step_cycle();
            guard++;
            if (bus.frame_tick) cnt++;
        end
    endtask

    initial begin
        int seen;
        bus.state = 2'b00; bus.hit = 1'b0; bus.no_birds_left = 1'b0;
        repeat (3) step_cycle();
        Reset = 1'b0;
        @(negedge Clk);
        chk("rst_active", 32'(bus.bird_active), 0);
        chk("rst_falling", 32'(bus.bird_falling), 0);
        chk("rst_flew", 32'(bus.flew_away), 0);
        chk("rst_timer", 32'(bus.phase_timer), 0);
        chk("rst_launched", bus.birds_launched, 0);
        chk("rst_shot", bus.birds_shot, 0);

        // Escape
        step_cycle();
        bus.state = 2'b01;
        wait_level("esc_active", 0, 1'b1, 200);
        wait_level("esc_flew", 2, 1'b1, 200);
        chk("esc_launched", bus.birds_launched, 1);
        chk("esc_shot", bus.birds_shot, 0);
        wait_level("esc_flew_low", 2, 1'b0, 50);

        // Hit two ticks into the flight
        wait_level("hit_active", 0, 1'b1, 200);
        wait_ticks(2);
        step_cycle();
        bus.hit = 1'b1;
        step_cycle();
        bus.hit = 1'b0;
        chk("hit_falling", 32'(bus.bird_falling), 1);
        chk("hit_shot", bus.birds_shot, 1);
        wait_level("hit_fall_end", 1, 1'b0, 200);

        // Hit on the escaping tick
        wait_level("sim_active", 0, 1'b1, 200);
        wait_ticks(4);
        bus.hit = 1'b1;
        step_cycle();
        bus.hit = 1'b0;
        chk("sim_falling", 32'(bus.bird_falling), 1);
        chk("sim_flew", 32'(bus.flew_away), 0);
        chk("sim_shot", bus.birds_shot, 2);

        // Random play
        for (int i = 0; i < 2000; i++) begin
            step_cycle();
            bus.hit = ($urandom_range(0, 15) == 0);
            Reset = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 199) == 0) bus.state = 2'($urandom_range(0, 3));
            else if (bus.state != 2'b01 && $urandom_range(0, 29) == 0) bus.state = 2'b01;
            if ($urandom_range(0, 249) == 0) bus.no_birds_left = ~bus.no_birds_left;
        end
        step_cycle();
        bus.hit = 1'b0; Reset = 1'b0; bus.no_birds_left = 1'b0; bus.state = 2'b10;
        repeat (3) step_cycle();
        bus.state = 2'b01;

        // Game end and restart
        wait_level("end_flew", 2, 1'b1, 400);
        wait_level("end_flew_low", 2, 1'b0, 50);
        bus.no_birds_left = 1'b1;
        seen = 0;
        repeat (80) begin
            step_cycle();
            if (bus.bird_active) seen = 1;
        end
        chk("done_no_launch", 32'(seen), 0);
        chk("done_launched", bus.birds_launched, 1);
        bus.state = 2'b10;
        repeat (2) step_cycle();
        bus.no_birds_left = 1'b0;
        bus.state = 2'b01;
        step_cycle();
        chk("new_launched", bus.birds_launched, 0);
        chk("new_shot", bus.birds_shot, 0);
        wait_level("new_active", 0, 1'b1, 200);
        chk("new_first", bus.birds_launched, 1);

        // Abort mid-flight
        wait_ticks(1);
        bus.state = 2'b00;
        step_cycle();
        chk("abort_active", 32'(bus.bird_active), 0);
        chk("abort_launched", bus.birds_launched, 1);
        chk("abort_timer", 32'(bus.phase_timer), 0);
        bus.state = 2'b01;

        // Reset while escaping
        wait_level("rst_esc_flew", 2, 1'b1, 300);
        chk("rst_esc_launched", bus.birds_launched, 2);
        Reset = 1'b1;
        step_cycle();
        Reset = 1'b0;
        chk("rst_esc_flew_low", 32'(bus.flew_away), 0);
        chk("rst_esc_active", 32'(bus.bird_active), 0);
        chk("rst_esc_launched0", bus.birds_launched, 0);
        bus.state = 2'b00;
        repeat (20) step_cycle();
        chk("scoreboard_drain", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
